// File: rtl/if_fetch_buffer.sv
// Fetch response buffer: DEPTH-entry FIFO of {rdata, err, addr} between the instruction memory and decode.
// Latency: one cycle from accepted push to out_*. With IF_FETCH_BUFFER_BYPASS_EN, an empty buffer passes the response through combinationally.
// Backpressure: in_ready_o drops only when full and is independent of out_ready_i; out_* hold stable while stalled.
module if_fetch_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_rdata_i,
  input  logic                       in_err_i,
  input  logic [ADDR_W-1:0]          in_addr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_rdata_o,
  output logic                       out_err_o,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_seen_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Pointer wrap relies on DEPTH being a power of two; catch bad configurations at elaboration.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("if_fetch_buffer: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_seen_q, err_seen_d;

  logic [DATA_W-1:0] mem_rdata_q [DEPTH];
  logic              mem_err_q   [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q  [DEPTH];

  logic              stored_vld;
  logic              push_acc;
  logic              pop_acc;
  logic              wr_en;
  logic              rd_adv;

  // Handshake, output mux and next-state; flush overrides any push/pop in the same cycle.
  always_comb begin
    stored_vld  = (count_q != '0);
    in_ready_o  = (count_q != CNT_W'(DEPTH));

    out_valid_o = stored_vld;
    out_rdata_o = '0;
    out_err_o   = 1'b0;
    out_addr_o  = '0;
    if (stored_vld) begin
      out_rdata_o = mem_rdata_q[rd_ptr_q];
      out_err_o   = mem_err_q[rd_ptr_q];
      out_addr_o  = mem_addr_q[rd_ptr_q];
    end
`ifdef IF_FETCH_BUFFER_BYPASS_EN
    // Empty buffer: present the incoming response directly.
    if (!stored_vld && in_valid_i && !flush_i) begin
      out_valid_o = 1'b1;
      out_rdata_o = in_rdata_i;
      out_err_o   = in_err_i;
      out_addr_o  = in_addr_i;
    end
`endif

    push_acc = in_valid_i & in_ready_o;
    pop_acc  = out_valid_o & out_ready_i;
    wr_en    = push_acc;
    rd_adv   = pop_acc;
`ifdef IF_FETCH_BUFFER_BYPASS_EN
    // A bypassed response that is consumed right away never touches storage.
    if (!stored_vld) begin
      wr_en  = push_acc & ~out_ready_i;
      rd_adv = 1'b0;
    end
`endif
    if (flush_i) begin
      wr_en  = 1'b0;
      rd_adv = 1'b0;
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_adv);
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
    err_seen_d = err_seen_q | (pop_acc & out_err_o);
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      err_seen_d = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_seen_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_seen_q <= err_seen_d;
    end
  end

  // Entry storage, written only on accepted pushes and never reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem_rdata_q[wr_ptr_q] <= in_rdata_i;
      mem_err_q[wr_ptr_q]   <= in_err_i;
      mem_addr_q[wr_ptr_q]  <= in_addr_i;
    end
  end

  assign count_o    = count_q;
  assign err_seen_o = err_seen_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef IF_FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni, flush_i, in_valid_i, in_err_i, out_ready_i;
  logic [31:0] in_rdata_i, in_addr_i;
  logic        in_ready_o, out_valid_o, out_err_o, err_seen_o;
  logic [31:0] out_rdata_o, out_addr_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata_i),
    .in_err_i(in_err_i), .in_addr_i(in_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o),
    .out_err_o(out_err_o), .out_addr_o(out_addr_o),
    .count_o(count_o), .err_seen_o(err_seen_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of entries plus the sticky error bit.
  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
  } ent_t;
  ent_t q[$];
  bit   m_err = 1'b0;
  bit   known = 1'b0;
  bit   can_push;

  always @(posedge clk) begin
    if (!rst_ni) begin
      q.delete();
      m_err = 1'b0;
      known = 1'b1;
    end else if (known) begin
      if (flush_i) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        can_push = (q.size() < DEPTH);
        if (BYP && q.size() == 0 && in_valid_i && out_ready_i) begin
          if (in_err_i) m_err = 1'b1;
        end else begin
          if (q.size() > 0 && out_ready_i) begin
            if (q[0].e) m_err = 1'b1;
            void'(q.pop_front());
          end
          if (in_valid_i && can_push) q.push_back('{d: in_rdata_i, e: in_err_i, a: in_addr_i});
        end
      end
    end
  end

  logic        e_v, e_e;
  logic [31:0] e_d, e_a;
  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (known) begin
      e_v = 1'b0; e_d = '0; e_e = 1'b0; e_a = '0;
      if (q.size() > 0) begin
        e_v = 1'b1; e_d = q[0].d; e_e = q[0].e; e_a = q[0].a;
      end else if (BYP && in_valid_i && !flush_i) begin
        e_v = 1'b1; e_d = in_rdata_i; e_e = in_err_i; e_a = in_addr_i;
      end
      chk("m_count", count_o, q.size());
      chk("m_in_ready", in_ready_o, q.size() < DEPTH);
      chk("m_out_valid", out_valid_o, e_v);
      chk("m_out_rdata", out_rdata_o, e_d);
      chk("m_out_err", out_err_o, e_e);
      chk("m_out_addr", out_addr_o, e_a);
      chk("m_err_seen", err_seen_o, m_err);
    end
  end

  task automatic set_in(input logic v, input logic [31:0] d, input logic e, input logic [31:0] a);
    in_valid_i = v; in_rdata_i = d; in_err_i = e; in_addr_i = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'h00000013; words[1] = 32'h00100093;
    words[2] = 32'h00200113; words[3] = 32'h00300193;
    rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_count", count_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_err_seen", err_seen_o, 0);
    rst_ni = 1'b1;

    // Fill to full, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, words[i], 1'b0, 32'h80 + 32'(4 * i));
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("fill_count", count_o, 4);
    chk("fill_in_ready", in_ready_o, 0);
    chk("fill_head", out_rdata_o, 32'h00000013);
    chk("fill_head_addr", out_addr_o, 32'h80);
    set_in(1'b1, 32'h0BAD0BAD, 1'b0, 32'h90);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("fifth_push_count", count_o, 4);

    // Drain in order.
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_rdata_o, words[i]);
      chk("drain_addr", out_addr_o, 32'h80 + 32'(4 * i));
      tick();
      chk("drain_count", count_o, 64'(3 - i));
    end
    chk("empty_valid", out_valid_o, 0);
    chk("empty_rdata", out_rdata_o, 0);
    chk("empty_addr", out_addr_o, 0);
    out_ready_i = 1'b0;

    // Full with simultaneous push and pop: the push is refused.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h1000 + 32'(i), 1'b0, 32'h400 + 32'(4 * i));
      tick();
    end
    set_in(1'b1, 32'h2000, 1'b0, 32'h500);
    out_ready_i = 1'b1;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("full_pushpop_count", count_o, 3);
    chk("full_pushpop_head", out_rdata_o, 32'h1001);
    tick(); tick(); tick();
    chk("full_pushpop_drained", count_o, 0);
    out_ready_i = 1'b0;

    // Steady state at count=2 with pointer wrap.
    set_in(1'b1, 32'h3000, 1'b0, 32'h600); tick();
    set_in(1'b1, 32'h3001, 1'b0, 32'h604); tick();
    out_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 32'h3002 + 32'(k), 1'b0, 32'h608 + 32'(4 * k));
      chk("wrap_head", out_rdata_o, 32'h3000 + 32'(k));
      tick();
      chk("wrap_count", count_o, 2);
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    out_ready_i = 1'b0;

    // Flush at count=3 with a concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h4000 + 32'(i), 1'b0, 32'h700 + 32'(4 * i));
      tick();
    end
    set_in(1'b1, 32'hFFFF0000, 1'b0, 32'h7F0);
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; out_ready_i = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_in_ready", in_ready_o, 1);
    set_in(1'b1, 32'h4100, 1'b0, 32'h800);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_flush_head", out_rdata_o, 32'h4100);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;

    // Sticky error: set on pop, cleared by flush, then by reset.
    set_in(1'b1, 32'h5000, 1'b1, 32'h100); tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    chk("err_before_pop", err_seen_o, 0);
    chk("err_head_flag", out_err_o, 1);
    chk("err_head_addr", out_addr_o, 32'h100);
    tick();
    chk("err_still_clear", err_seen_o, 0);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    chk("err_after_pop", err_seen_o, 1);
    tick();
    chk("err_holds", err_seen_o, 1);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    chk("err_flush_clear", err_seen_o, 0);
    set_in(1'b1, 32'h5001, 1'b1, 32'h104); tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    chk("err_after_pop2", err_seen_o, 1);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    chk("err_reset_clear", err_seen_o, 0);

    // Empty buffer, response arriving with consumer ready.
    set_in(1'b1, 32'hDEADBEEF, 1'b0, 32'h200);
    out_ready_i = 1'b1;
    #1;
    chk("byp_same_valid", out_valid_o, BYP);
    chk("byp_same_rdata", out_rdata_o, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("byp_next_valid", out_valid_o, !BYP);
    chk("byp_next_count", count_o, BYP ? 0 : 1);
    chk("byp_next_rdata", out_rdata_o, BYP ? 32'h0 : 32'hDEADBEEF);
    tick();
    out_ready_i = 1'b0;

    // Mixed traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0), $urandom);
      out_ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      rst_ni      = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_ni = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
